// File: rtl/alb_pkg.sv
// Shared definitions for the ALB multi-precision sequencer: slice opcodes and
// the sequencer state encoding.
package alb_pkg;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ANDN = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/alb_mp_sequencer.sv
// Word-serial initiator for a single ALB slice: splits a wide operation into
// DATA_WIDTH words (LSB first), chains carry through the slice and reassembles the result.
module alb_mp_sequencer
    import alb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_op,
    input  logic [WORDS*DATA_WIDTH-1:0]   in_a,
    input  logic [WORDS*DATA_WIDTH-1:0]   in_b,
    input  logic                          in_ci,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORDS*DATA_WIDTH-1:0]   out_f,
    output logic                          out_co,
    output logic                          out_vo,
    output logic                          out_no,
    output logic                          out_zo,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    output logic                          alu_ci,
    output logic [1:0]                    alu_i,
    input  logic [DATA_WIDTH-1:0]         alu_f,
    input  logic                          alu_co,
    input  logic                          alu_vo,
    input  logic                          alu_no,
    input  logic                          alu_zo
);

    localparam int              W      = WORDS * DATA_WIDTH;
    localparam int              KW     = $clog2(WORDS);
    localparam logic [KW-1:0]   K_LAST = KW'(WORDS - 1);

    seq_state_t          state, next_state;
    logic [KW-1:0]       k;
    logic [KW-1:0]       k_prev;
    logic [1:0]          op_q;
    logic [W-1:0]        a_q, b_q, f_q;
    logic                ci_q;
    logic                zacc_q;
    logic                co_q, vo_q, no_q, zo_q;
    logic                unused_flags;

    // The slice's own N/Z only describe one word, so whole-word flags are rebuilt here.
    assign unused_flags = alu_no ^ alu_zo;

    assign k_prev = k - KW'(1);

    assign out_f  = f_q;
    assign out_co = co_q;
    assign out_vo = vo_q;
    assign out_no = no_q;
    assign out_zo = zo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ci     = 1'b0;
        alu_i      = 2'b00;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_a  = a_q[int'(k)*DATA_WIDTH +: DATA_WIDTH];
                alu_b  = b_q[int'(k)*DATA_WIDTH +: DATA_WIDTH];
                // Previous word's carry arrives combinationally from the slice this cycle.
                alu_ci = (k == '0) ? ci_q : alu_co;
                alu_i  = op_q;
                if (k == K_LAST) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                alu_i      = op_q;
                next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= '0;
            op_q   <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
            ci_q   <= 1'b0;
            f_q    <= '0;
            zacc_q <= 1'b0;
            co_q   <= 1'b0;
            vo_q   <= 1'b0;
            no_q   <= 1'b0;
            zo_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_op;
                        a_q    <= in_a;
                        b_q    <= in_b;
                        ci_q   <= in_ci;
                        k      <= '0;
                        f_q    <= '0;
                        zacc_q <= 1'b1;
                        co_q   <= 1'b0;
                        vo_q   <= 1'b0;
                        no_q   <= 1'b0;
                        zo_q   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (k != '0) begin
                        f_q[int'(k_prev)*DATA_WIDTH +: DATA_WIDTH] <= alu_f;
                        zacc_q <= zacc_q & (alu_f == '0);
                    end
                    k <= (k == K_LAST) ? '0 : k + KW'(1);
                end
                S_DRAIN: begin
                    f_q[(WORDS-1)*DATA_WIDTH +: DATA_WIDTH] <= alu_f;
                    co_q <= alu_co;
                    vo_q <= alu_vo;
                    no_q <= alu_f[DATA_WIDTH-1];
                    zo_q <= zacc_q & (alu_f == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alb_mp_sequencer.sv
// Bench for alb_mp_sequencer: an inline ALB slice responder plus a full-width
// arithmetic reference model, driven by directed and random operations.
module tb_alb_mp_sequencer;
    import alb_pkg::*;

    localparam int DW    = 8;
    localparam int WORDS = 4;
    localparam int W     = DW * WORDS;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic          in_ci;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_f;
    logic          out_co, out_vo, out_no, out_zo;
    logic [DW-1:0] alu_a, alu_b, alu_f;
    logic          alu_ci;
    logic [1:0]    alu_i;
    logic          alu_co, alu_vo, alu_no, alu_zo;

    int errorCount = 0;
    int checkCount = 0;

    alb_mp_sequencer #(.DATA_WIDTH(DW), .WORDS(WORDS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
        .out_co(out_co), .out_vo(out_vo), .out_no(out_no), .out_zo(out_zo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_i(alu_i),
        .alu_f(alu_f), .alu_co(alu_co), .alu_vo(alu_vo), .alu_no(alu_no), .alu_zo(alu_zo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALB slice responder: operands registered, opcode used live.
    logic [DW-1:0] sliceA, sliceB;
    logic          sliceCi;
    logic [DW:0]   sliceSum;

    always_ff @(posedge clk) begin
        sliceA  <= alu_a;
        sliceB  <= alu_b;
        sliceCi <= alu_ci;
    end

    always_comb begin
        sliceSum = '0;
        alu_f    = '0;
        alu_co   = 1'b0;
        alu_vo   = 1'b0;
        case (alu_i)
            OP_OR:   alu_f = sliceB | sliceA;
            OP_ANDN: alu_f = ~sliceB & sliceA;
            OP_ADD: begin
                sliceSum = {1'b0, sliceB} + {1'b0, sliceA} + {{DW{1'b0}}, sliceCi};
                alu_f    = sliceSum[DW-1:0];
                alu_co   = sliceSum[DW];
                alu_vo   = (sliceA[DW-1] == sliceB[DW-1]) && (alu_f[DW-1] != sliceA[DW-1]);
            end
            default: begin
                sliceSum = {1'b0, sliceB} + {1'b0, ~sliceA} + {{DW{1'b0}}, sliceCi};
                alu_f    = sliceSum[DW-1:0];
                alu_co   = sliceSum[DW];
                alu_vo   = (sliceA[DW-1] != sliceB[DW-1]) && (alu_f[DW-1] != sliceB[DW-1]);
            end
        endcase
        alu_no = alu_f[DW-1];
        alu_zo = (alu_f == '0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Whole-operand reference: the result is just W-bit arithmetic on a and b.
    task automatic refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, output logic [W-1:0] f, output logic co, output logic vo);
        logic [W:0] wide;
        f  = '0;
        co = 1'b0;
        vo = 1'b0;
        case (op)
            OP_OR:   f = b | a;
            OP_ANDN: f = ~b & a;
            OP_ADD: begin
                wide = {1'b0, b} + {1'b0, a} + (W+1)'(ci);
                f    = wide[W-1:0];
                co   = wide[W];
                vo   = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
            end
            default: begin
                wide = {1'b0, b} - {1'b0, a} - (W+1)'(1) + (W+1)'(ci);
                f    = wide[W-1:0];
                co   = !wide[W];
                vo   = (a[W-1] != b[W-1]) && (f[W-1] != b[W-1]);
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input int holdCycles);
        logic [W-1:0] expF;
        logic         expCo, expVo;
        int           n;
        refModel(op, a, b, ci, expF, expCo, expVo);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        @(posedge clk); #1;
        n = 1;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom);
            in_op    = 2'($urandom);
            in_a     = $urandom;
            in_b     = $urandom;
            in_ci    = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checkOutput("latency", 32'(n), 32'(WORDS + 2));
        checkOutput("out_valid", 32'(out_valid), 32'd1);
        checkOutput("out_f", out_f, expF);
        checkOutput("out_co", 32'(out_co), 32'(expCo));
        checkOutput("out_vo", 32'(out_vo), 32'(expVo));
        checkOutput("out_no", 32'(out_no), 32'(expF[W-1]));
        checkOutput("out_zo", 32'(out_zo), 32'(expF == '0));
        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_f", out_f, expF);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("valid_drop", 32'(out_valid), 32'd0);
        checkOutput("ready_return", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int strayValid;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_f", out_f, 32'd0);
        checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_alu_i", 32'(alu_i), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(OP_ADD,  32'h0000_0001, 32'h0000_00FF, 1'b0, 0);
        applyStimulus(OP_ADD,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(OP_ADD,  32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 0);
        applyStimulus(OP_SUB,  32'h0000_0001, 32'h0000_0100, 1'b1, 0);
        applyStimulus(OP_SUB,  32'h0000_0001, 32'h0000_0000, 1'b1, 0);
        applyStimulus(OP_OR,   32'h0F0F_00FF, 32'hF0F0_0000, 1'b1, 0);
        applyStimulus(OP_ANDN, 32'h0F0F_00FF, 32'hF0F0_0000, 1'b1, 0);
        applyStimulus(OP_ADD,  32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5);

        // Abort an operation while word 2 is on the slice.
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 32'h4433_2211;
        in_b     = 32'h0102_0304;
        in_ci    = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_word2", 32'(alu_a), 32'h33);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_f", out_f, 32'd0);
        strayValid = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) strayValid++;
        end
        checkOutput("abort_no_valid", 32'(strayValid), 32'd0);

        for (int r = 0; r < 40; r++) begin
            applyStimulus(2'($urandom), $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
